mem_stage_lsu: RTL
==================

Name: mem_stage_lsu

Overview:
- Parametrised successor to the pass-through MEM stage of the RISC-V pipeline. Sits between EX/MEM and WB.
- Registers the MEM/WB pipeline signals, which gives one cycle of latency.
- Runs the load/store path itself: byte/half/word sizing, byte enables, load sign/zero extension, misalignment detection, and a req/ack data-memory handshake with wait states, timeout and pipeline stall.

Parameters:
- XLEN, 32, datapath and address width; multiple of 8.
- REG_W, 5, register-index width.
- TIMEOUT, 255, max cycles waiting for dmem_ack before abort; must be >=1.
- CNT_W, $clog2(TIMEOUT+1), width of the wait counter.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- in_valid  in  1  EX/MEM slot holds a valid instruction.
- flush_in  in  1  kill the instruction in this stage.
- alu_in  in  XLEN  ALU result / effective address.
- write_data2_in  in  XLEN  store data (rs2).
- pc_data_in  in  XLEN  PC-derived value for WB.
- funct3_in  in  3  access size/sign.
- reg_write_in, mem_read_in, mem_write_in, mem_to_reg_in  in  1 each  control bits.
- write_reg_in  in  REG_W  destination register.
- dmem_req  out  1  memory request.
- dmem_we  out  1  1 = store.
- dmem_addr  out  XLEN  byte address.
- dmem_wdata  out  XLEN  lane-replicated store data.
- dmem_be  out  XLEN/8  byte enables.
- dmem_ack  in  1  request completed; rdata valid on loads.
- dmem_rdata  in  XLEN  raw load word.
- stall_out  out  1  upstream must hold its inputs.
- misalign_out  out  1  one-cycle fault pulse (misaligned or illegal funct3).
- bus_err_out  out  1  one-cycle timeout pulse.
- wb_valid, wb_reg_write, wb_mem_to_reg  out  1 each  MEM/WB outputs.
- wb_read_data, wb_alu, wb_pc_data  out  XLEN  MEM/WB outputs.
- wb_write_reg  out  REG_W  MEM/WB output.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: state IDLE; wait counter 0; dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be 0; all wb_* 0; misalign_out 0; bus_err_out 0.
- Definitions:
  - memop = mem_read_in | mem_write_in.
  - bad = memop & ((funct3 in {011,110,111}) | (half access & addr[0]) | (word access & addr[1:0]!=0)).
- FSM, IDLE state:
  - Non-memop, or flush_in: the next edge registers the inputs into wb_*. wb_valid = in_valid & ~flush_in.
  - in_valid & memop & bad & ~flush: no bus access. Next edge: wb_valid=1, wb_reg_write=0, misalign_out=1 for one cycle.
  - in_valid & memop & ~bad & ~flush: latch address, be, wdata, funct3 and control bits, then go to BUSY. wb_valid=0 on that edge. stall_out=1 combinationally in this cycle.
- FSM, BUSY state:
  - dmem_req=1, with address/we/be/wdata held stable until ack.
  - stall_out = ~dmem_ack.
  - The counter increments each cycle without ack.
  - On dmem_ack: load formatting is applied to dmem_rdata. Next edge: wb_* written, wb_valid=1, go to IDLE, counter cleared.
  - On counter==TIMEOUT without ack: abort. Next edge: dmem_req=0, wb_valid=1, wb_reg_write=0, bus_err_out pulses, go to IDLE. stall_out=0 in that cycle.
- Minimum memory-op latency: 2 edges (accept, then ack in the first BUSY cycle).
- flush_in during BUSY: recorded in a kill flag. The bus transaction still completes (stores commit). The result is issued with wb_valid=0 and wb_reg_write=0.
- Load formatting:
  - Lane = addr[1:0] (byte) or addr[1] (half).
  - LB/LH sign-extend; LBU/LHU zero-extend; LW is passed as-is.
- Store formatting:
  - SB: byte replicated on all lanes, be = 1<<addr[1:0].
  - SH: half replicated, be = 0011<<(2*addr[1]).
  - SW: be all ones.
- dmem_we = mem_write. Loads drive be from size as well.
- While dmem_req is high, the inputs are don't-care.
- Reset mid-BUSY: drops dmem_req immediately (asynchronously); the in-flight op is discarded.
- dmem_ack in IDLE is ignored.

Decomposition:
- Shared package (riscv_pkg):
  - funct3 load/store encodings (LB, LH, LW, LBU, LHU, SB, SH, SW).
  - lsu_state_t enum {IDLE, BUSY}.
  - mem_wb_t struct holding the WB bundle.
- One natural sub-module: lsu_align. Purely combinational; performs store lane/be generation, load extraction/extension and bad detection.

Test Plan:
- ALU op: in_valid=1, memop=0, alu_in=0x1234, write_reg=5, reg_write=1 -> next edge wb_alu=0x1234, wb_write_reg=5, wb_valid=1; stall_out=0 throughout.
- LB: alu_in=0x103, funct3=000, ack on first BUSY cycle with rdata=0x80AABBCC -> wb_read_data=0xFFFFFF80 two edges after accept; LBU at the same address -> 0x00000080.
- SH: alu_in=0x102, data=0x0000BEEF, ack after 3 wait cycles -> dmem_be=1100, dmem_wdata=0xBEEFBEEF, dmem_we=1, held stable 4 cycles; stall_out high until the ack cycle.
- Misaligned LW: alu_in=0x1001 -> dmem_req never asserted; misalign_out one-cycle pulse; wb_valid=1, wb_reg_write=0.
- Timeout: TIMEOUT=4, no ack -> dmem_req drops after 5 BUSY cycles; bus_err_out pulse; wb_reg_write=0; FSM back in IDLE.
- Flush mid-BUSY, then a separate op: flush during BUSY then ack -> wb_valid=0. Assert rst in BUSY -> dmem_req and all wb_* 0 immediately.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared encodings and types for the MEM stage load/store unit.
package riscv_pkg;

  // Load funct3 encodings
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // Store funct3 encodings
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } lsu_state_t;

  // Width-independent control part of the MEM/WB bundle; the data part is
  // sized by the stage parameters and lives in mem_stage_lsu.
  typedef struct packed {
    logic valid;
    logic reg_write;
    logic mem_to_reg;
  } wb_ctl_t;

  // funct3 values that name no load/store size at all
  function automatic logic f3_illegal(input logic [2:0] f3);
    return (f3 == 3'b011) || (f3[2:1] == 2'b11);
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: store replication and byte enables, load
// extraction with sign/zero extension, and misalignment/illegal detection.
module lsu_align
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [1:0]        addr_lo,
  input  logic [2:0]        funct3,
  input  logic              memop,
  input  logic [XLEN-1:0]   store_data,
  input  logic [XLEN-1:0]   rdata,
  output logic [XLEN/8-1:0] be,
  output logic [XLEN-1:0]   wdata,
  output logic [XLEN-1:0]   load_data,
  output logic              bad
);

  localparam int NB = XLEN / 8;

  logic [7:0]  rbyte;
  logic [15:0] rhalf;
  logic        is_unsigned;

  // Size decode on funct3[1:0]; funct3[2] selects zero extension for loads
  always_comb begin
    rbyte       = rdata[{addr_lo, 3'b000} +: 8];
    rhalf       = rdata[{addr_lo[1], 4'b0000} +: 16];
    is_unsigned = funct3[2];
    be          = '1;
    wdata       = store_data;
    load_data   = rdata;
    bad         = 1'b0;
    case (funct3[1:0])
      2'b00: begin
        be        = NB'(1) << addr_lo;
        wdata     = {NB{store_data[7:0]}};
        load_data = is_unsigned ? XLEN'(rbyte) : {{(XLEN-8){rbyte[7]}}, rbyte};
      end
      2'b01: begin
        be        = NB'(3) << {addr_lo[1], 1'b0};
        wdata     = {(NB/2){store_data[15:0]}};
        load_data = is_unsigned ? XLEN'(rhalf) : {{(XLEN-16){rhalf[15]}}, rhalf};
        bad       = addr_lo[0];
      end
      2'b10:   bad = |addr_lo;
      default: bad = 1'b1;
    endcase
    if (f3_illegal(funct3)) bad = 1'b1;
    bad = bad & memop;
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM stage with integrated load/store unit: registers MEM/WB and runs a
// req/ack data-memory handshake with wait states, timeout and stall.
//
// state | meaning
// IDLE  | pass-through; accepts a legal memop and latches the request
// BUSY  | dmem_req held; waits for ack or timeout, then writes back
module mem_stage_lsu
  import riscv_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int REG_W   = 5,
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = $clog2(TIMEOUT+1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic              flush_in,
  input  logic [XLEN-1:0]   alu_in,
  input  logic [XLEN-1:0]   write_data2_in,
  input  logic [XLEN-1:0]   pc_data_in,
  input  logic [2:0]        funct3_in,
  input  logic              reg_write_in,
  input  logic              mem_read_in,
  input  logic              mem_write_in,
  input  logic              mem_to_reg_in,
  input  logic [REG_W-1:0]  write_reg_in,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [XLEN-1:0]   dmem_addr,
  output logic [XLEN-1:0]   dmem_wdata,
  output logic [XLEN/8-1:0] dmem_be,
  input  logic              dmem_ack,
  input  logic [XLEN-1:0]   dmem_rdata,
  output logic              stall_out,
  output logic              misalign_out,
  output logic              bus_err_out,
  output logic              wb_valid,
  output logic              wb_reg_write,
  output logic              wb_mem_to_reg,
  output logic [XLEN-1:0]   wb_read_data,
  output logic [XLEN-1:0]   wb_alu,
  output logic [XLEN-1:0]   wb_pc_data,
  output logic [REG_W-1:0]  wb_write_reg
);

  typedef struct packed {
    wb_ctl_t          ctl;
    logic [XLEN-1:0]  read_data;
    logic [XLEN-1:0]  alu;
    logic [XLEN-1:0]  pc_data;
    logic [REG_W-1:0] write_reg;
  } mem_wb_t;

  lsu_state_t        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              kill_q, kill_d;
  logic              req_q, req_d, we_q, we_d;
  logic [XLEN-1:0]   addr_q, addr_d, wdata_q, wdata_d, pc_q, pc_d;
  logic [XLEN/8-1:0] be_q, be_d;
  logic [2:0]        f3_q, f3_d;
  logic              rw_q, rw_d, m2r_q, m2r_d;
  logic [REG_W-1:0]  wreg_q, wreg_d;
  mem_wb_t           wb_q, wb_d;
  logic              mis_q, mis_d, berr_q, berr_d;

  logic              memop, bad, killed;
  logic [XLEN/8-1:0] al_be;
  logic [XLEN-1:0]   al_wdata, al_load;

  assign memop  = mem_read_in | mem_write_in;
  assign killed = kill_q | flush_in;

  // In IDLE the aligner sees the incoming op; in BUSY it formats the load
  // using the latched address and size.
  lsu_align #(.XLEN(XLEN)) u_align (
    .addr_lo    (state_q == BUSY ? addr_q[1:0] : alu_in[1:0]),
    .funct3     (state_q == BUSY ? f3_q : funct3_in),
    .memop      (memop),
    .store_data (write_data2_in),
    .rdata      (dmem_rdata),
    .be         (al_be),
    .wdata      (al_wdata),
    .load_data  (al_load),
    .bad        (bad)
  );

  // Next-state, request latching and write-back selection
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    kill_d  = kill_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    f3_d    = f3_q;
    rw_d    = rw_q;
    m2r_d   = m2r_q;
    pc_d    = pc_q;
    wreg_d  = wreg_q;
    wb_d    = '0;
    mis_d   = 1'b0;
    berr_d  = 1'b0;
    stall_out = 1'b0;
    case (state_q)
      IDLE: begin
        kill_d = 1'b0;
        cnt_d  = '0;
        if (in_valid && memop && !flush_in) begin
          if (bad) begin
            wb_d.ctl.valid      = 1'b1;
            wb_d.ctl.mem_to_reg = mem_to_reg_in;
            wb_d.alu            = alu_in;
            wb_d.pc_data        = pc_data_in;
            wb_d.write_reg      = write_reg_in;
            mis_d               = 1'b1;
          end else begin
            state_d   = BUSY;
            req_d     = 1'b1;
            we_d      = mem_write_in;
            addr_d    = alu_in;
            wdata_d   = al_wdata;
            be_d      = al_be;
            f3_d      = funct3_in;
            rw_d      = reg_write_in;
            m2r_d     = mem_to_reg_in;
            pc_d      = pc_data_in;
            wreg_d    = write_reg_in;
            stall_out = 1'b1;
          end
        end else begin
          wb_d.ctl.valid      = in_valid & ~flush_in;
          wb_d.ctl.reg_write  = reg_write_in & in_valid & ~flush_in;
          wb_d.ctl.mem_to_reg = mem_to_reg_in;
          wb_d.alu            = alu_in;
          wb_d.pc_data        = pc_data_in;
          wb_d.write_reg      = write_reg_in;
        end
      end
      BUSY: begin
        kill_d = killed;
        if (dmem_ack || (cnt_q == CNT_W'(TIMEOUT))) begin
          state_d             = IDLE;
          cnt_d               = '0;
          req_d               = 1'b0;
          wb_d.ctl.valid      = ~killed;
          wb_d.ctl.reg_write  = dmem_ack & rw_q & ~killed;
          wb_d.ctl.mem_to_reg = m2r_q;
          wb_d.read_data      = dmem_ack ? al_load : '0;
          wb_d.alu            = addr_q;
          wb_d.pc_data        = pc_q;
          wb_d.write_reg      = wreg_q;
          berr_d              = ~dmem_ack;
        end else begin
          cnt_d     = cnt_q + CNT_W'(1);
          stall_out = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and pipeline registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      kill_q  <= 1'b0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      f3_q    <= '0;
      rw_q    <= 1'b0;
      m2r_q   <= 1'b0;
      pc_q    <= '0;
      wreg_q  <= '0;
      wb_q    <= '0;
      mis_q   <= 1'b0;
      berr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      kill_q  <= kill_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      f3_q    <= f3_d;
      rw_q    <= rw_d;
      m2r_q   <= m2r_d;
      pc_q    <= pc_d;
      wreg_q  <= wreg_d;
      wb_q    <= wb_d;
      mis_q   <= mis_d;
      berr_q  <= berr_d;
    end
  end

  assign dmem_req      = req_q;
  assign dmem_we       = we_q;
  assign dmem_addr     = addr_q;
  assign dmem_wdata    = wdata_q;
  assign dmem_be       = be_q;
  assign misalign_out  = mis_q;
  assign bus_err_out   = berr_q;
  assign wb_valid      = wb_q.ctl.valid;
  assign wb_reg_write  = wb_q.ctl.reg_write;
  assign wb_mem_to_reg = wb_q.ctl.mem_to_reg;
  assign wb_read_data  = wb_q.read_data;
  assign wb_alu        = wb_q.alu;
  assign wb_pc_data    = wb_q.pc_data;
  assign wb_write_reg  = wb_q.write_reg;

endmodule
